// File: rtl/avalon_slew_pio_pkg.sv
// Shared register map and CTRL bit positions for the slew-limited PIO.
package avalon_slew_pio_pkg;
  localparam int CTRL_OFS     = 0;
  localparam int PRESCALE_OFS = 1;
  localparam int STEP_OFS     = 2;
  localparam int STATUS_OFS   = 3;
  localparam int TARGET_BASE  = 4;

  localparam int SLEW_EN_BIT  = 0;
  localparam int IRQ_EN_BIT   = 1;
endpackage

// File: rtl/avalon_slew_pio_if.sv
// Avalon-MM slave bus bundle (zero read latency, no waitrequest).
interface avalon_slew_pio_if #(parameter int ADDR_W = 4);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/avalon_slew_pio_slew_channel.sv
// One output channel: a software target and a current value that walks
// toward it by at most STEP per prescaler tick while slewing is enabled.
module slew_channel
  import avalon_slew_pio_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             slew_en,
  input  logic [WIDTH-1:0] step,
  input  logic             target_we,
  input  logic [WIDTH-1:0] target_wdata,
  output logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] current,
  output logic             busy,
  output logic             done_pulse
);

  logic             up;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] delta;

  // Clamping the move to the remaining distance prevents overshoot and wrap.
  always_comb begin
    up    = target > current;
    diff  = up ? (target - current) : (current - target);
    delta = (step < diff) ? step : diff;
  end

  assign busy       = current != target;
  assign done_pulse = slew_en && tick && (diff != '0) && (step >= diff);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target  <= '0;
      current <= '0;
    end else begin
      if (target_we)
        target <= target_wdata;
      if (!slew_en)
        current <= target;
      else if (tick && (diff != '0))
        current <= up ? (current + delta) : (current - delta);
    end
  end

endmodule

// File: rtl/avalon_slew_pio.sv
// Multi-channel Avalon-MM PIO whose outputs slew toward software targets,
// with a shared prescaler, per-channel busy/done status and a level irq.
module avalon_slew_pio
  import avalon_slew_pio_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 4,
  parameter int PRE_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  avalon_slew_pio_if.slave          bus,
  output logic [CHANNELS*WIDTH-1:0] out_port,
  output logic                      irq
);

  logic [1:0]          ctrl;
  logic [PRE_W-1:0]    prescale;
  logic [PRE_W-1:0]    pc;
  logic [WIDTH-1:0]    step;
  logic [CHANNELS-1:0] done;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] done_pulse;
  logic [CHANNELS-1:0] w1c;
  logic [WIDTH-1:0]    targets  [CHANNELS];
  logic [WIDTH-1:0]    currents [CHANNELS];
  logic                wr;
  logic                tick;

  assign wr   = bus.chipselect & ~bus.write_n;
  assign tick = pc == prescale;
  assign w1c  = (wr && bus.address == ADDR_W'(STATUS_OFS))
                ? bus.writedata[2*CHANNELS-1:CHANNELS] : '0;

  // Control registers and prescaler; a PRESCALE write restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl     <= '0;
      prescale <= '0;
      pc       <= '0;
      step     <= WIDTH'(1);
      done     <= '0;
    end else begin
      if (wr && bus.address == ADDR_W'(CTRL_OFS))
        ctrl <= bus.writedata[1:0];
      if (wr && bus.address == ADDR_W'(STEP_OFS))
        step <= bus.writedata[WIDTH-1:0];
      if (wr && bus.address == ADDR_W'(PRESCALE_OFS)) begin
        prescale <= bus.writedata[PRE_W-1:0];
        pc       <= '0;
      end else begin
        pc <= tick ? '0 : pc + PRE_W'(1);
      end
      done <= (done & ~w1c) | done_pulse;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    slew_channel #(.WIDTH(WIDTH)) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .tick         (tick),
      .slew_en      (ctrl[SLEW_EN_BIT]),
      .step         (step),
      .target_we    (wr && bus.address == ADDR_W'(TARGET_BASE + i)),
      .target_wdata (bus.writedata[WIDTH-1:0]),
      .target       (targets[i]),
      .current      (currents[i]),
      .busy         (busy[i]),
      .done_pulse   (done_pulse[i])
    );
    assign out_port[i*WIDTH +: WIDTH] = currents[i];
  end

  assign irq = ctrl[IRQ_EN_BIT] & (|done);

  always_comb begin
    bus.readdata = '0;
    if (bus.address == ADDR_W'(CTRL_OFS))
      bus.readdata = 32'(ctrl);
    else if (bus.address == ADDR_W'(PRESCALE_OFS))
      bus.readdata = 32'(prescale);
    else if (bus.address == ADDR_W'(STEP_OFS))
      bus.readdata = 32'(step);
    else if (bus.address == ADDR_W'(STATUS_OFS))
      bus.readdata = 32'({done, busy});
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.address == ADDR_W'(TARGET_BASE + i))
        bus.readdata = 32'(targets[i]);
      if (bus.address == ADDR_W'(TARGET_BASE + CHANNELS + i))
        bus.readdata = 32'(currents[i]);
    end
  end

endmodule

// File: doc/avalon_slew_pio.md
Name: avalon_slew_pio

Overview:
- Parametrised, multi-channel Avalon-MM output port (PIO) for driving gauge/indicator outputs.
- Each channel holds a software-written target and a current output value.
- With slewing enabled, the current value moves toward the target by at most STEP per prescaler tick; with slewing disabled, it follows the target like a plain PIO.
- Provides per-channel busy/done status and a level interrupt; sits on the system Avalon bus alongside the other PIO peripherals.

Parameters:
- WIDTH, 12: bits per channel value.
- CHANNELS, 4: number of output channels. Constraint: 4 + 2*CHANNELS <= 2**ADDR_W.
- ADDR_W, 4: Avalon word-address width.
- PRE_W, 16: prescaler counter/register width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  ADDR_W  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, zero-extended, combinational (read latency 0, no waitrequest)
- out_port  out  CHANNELS*WIDTH  current values; channel i at bits [i*WIDTH +: WIDTH]
- irq  out  1  level interrupt

Behaviour:
- Write strobe `wr` = chipselect & ~write_n.
- Register map:
  - 0 CTRL: bit0 SLEW_EN, bit1 IRQ_EN; reset 0.
  - 1 PRESCALE: PRE_W bits; reset 0.
  - 2 STEP: WIDTH bits; reset 1.
  - 3 STATUS:
    - bits[C-1:0] BUSY: read-only, current != target.
    - bits[2C-1:C] DONE: sticky; write-1-to-clear.
  - 4+i TARGET[i]: read/write; reset 0.
  - 4+C+i CURRENT[i]: read-only.
  - Unmapped addresses read 0; writes to them are ignored.
  - Writes use only the low bits of writedata that fit the register.
- Reset: all registers, currents, prescaler counter and DONE bits are 0; STEP is 1; out_port = 0; irq = 0. Reset takes effect immediately (asynchronous) at any point, including mid-slew.
- Prescaler:
  - Counter pc counts 0..PRESCALE.
  - tick = (pc == PRESCALE); on tick, pc <= 0, otherwise pc + 1. PRESCALE = 0 gives a tick every cycle.
  - A write to PRESCALE loads the new value and clears pc to 0 in the same cycle.
- Per channel, evaluated each clock using register values before that cycle's write:
  - SLEW_EN = 0: current <= target (one-cycle latency from a TARGET write to out_port). DONE is not set.
  - SLEW_EN = 1 and tick:
    - d = |target - current| (unsigned, WIDTH bits, no overflow).
    - If d != 0: current moves toward target by min(STEP, d). Current never overshoots and never wraps.
    - If this step makes current == target, DONE[i] <= 1.
  - STEP = 0: the channel holds its value; BUSY stays set.
  - Neither condition above: current holds.
- Simultaneous events:
  - TARGET write coincident with a tick: the tick uses the old target; the new target applies from the next cycle.
  - DONE W1C coincident with a DONE set: set wins.
  - CTRL write disabling SLEW_EN: currents snap to targets on the following cycle.
- irq = IRQ_EN & |DONE. It is registered-free combinational from registers, so it updates the cycle after the cause.
- out_port is driven directly from the current registers, with no combinational path from the bus.

Decomposition:
- Package avalon_slew_pio_pkg holds:
  - register offsets CTRL_OFS = 0, PRESCALE_OFS = 1, STEP_OFS = 2, STATUS_OFS = 3, TARGET_BASE = 4;
  - CTRL bit indices SLEW_EN_BIT = 0, IRQ_EN_BIT = 1.
- Sub-module slew_channel (parameter WIDTH) holds one target/current pair.
  - Inputs: tick, slew_en, step, target write-enable and data.
  - Outputs: current, busy, done_pulse.
- The top level holds the bus decode, prescaler, CTRL/STEP/STATUS registers and the read mux, and instantiates CHANNELS copies of slew_channel in a generate loop.

Test Plan:
- Reset default / plain PIO:
  - Stimulus: write TARGET[0] = 0xABC with SLEW_EN = 0.
  - Response: out_port[11:0] = 0xABC one cycle later; CURRENT[0] reads 0xABC; BUSY = 0; DONE = 0; irq = 0.
- Slew up with prescale:
  - Stimulus: CTRL = 3, PRESCALE = 2, STEP = 0x100, TARGET[1] = 0x250.
  - Response: CURRENT[1] steps 0x100, 0x200, 0x250 on every 3rd cycle; BUSY[1] clears on the last step; DONE[1] = 1; irq = 1.
- Slew down, no overshoot/wrap:
  - Stimulus: from 0x250 with STEP = 0x300, TARGET[1] = 0x010.
  - Response: a single tick gives 0x010, never wrapping below 0.
- W1C and irq:
  - Stimulus: write STATUS with bit(C+1) = 1.
  - Response: DONE[1] = 0 and irq = 0 the next cycle.
  - Stimulus: W1C coincident with a completing step.
  - Response: DONE stays 1.
- Edge cases:
  - STEP = 0 with target != current: value frozen, BUSY = 1.
  - Clearing SLEW_EN: snaps to target next cycle, DONE not set.
  - TARGET write on a tick cycle: the tick moves toward the old target.
- Reset mid-slew:
  - Stimulus: assert reset_n = 0 asynchronously during ramps.
  - Response: out_port = 0, irq = 0 immediately; STEP reads 1; all other registers read 0.
